// File: rtl/trdb_pkg.sv
// trdb_pkg: shared types for the trace qualify tracker.
// Holds XLEN, the tracker FSM states and the held-entry struct.
package trdb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    STOPPED
  } qual_state_e;

  typedef struct packed {
    logic [XLEN-1:0] iaddr;
    logic            first;
    logic            last;
  } qual_entry_t;

endpackage

// File: rtl/trdb_qual_outreg.sv
// trdb_qual_outreg: single-entry valid/ready output register.
// Ports: wr_i/wr_entry_i push, ready_i pop, valid_o/entry_o data,
// overflow_o one-cycle pulse when a push finds the entry occupied.
module trdb_qual_outreg
  import trdb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  qual_entry_t wr_entry_i,
  input  logic        ready_i,
  output logic        valid_o,
  output qual_entry_t entry_o,
  output logic        overflow_o
);

  logic        r_valid;
  qual_entry_t r_entry;
  logic        r_ovf;
  logic        w_free;

  // Free when empty or being drained this cycle.
  assign w_free = !r_valid || ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_entry <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= wr_i && !w_free;
      if (wr_i && w_free) begin
        r_valid <= 1'b1;
        r_entry <= wr_entry_i;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o    = r_valid;
  assign entry_o    = r_entry;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/trdb_qualify_tracker.sv
// trdb_qualify_tracker: owns trace activation, buffers one qualified
// instruction and tags first/last of each qualified run.
// Ports: trace_enable_i/trace_activated_o activation, trace_qualified_i,
// trace_req_deactivate_i, ivalid_i/iaddr_i from filter, flush_i,
// out_* valid/ready emission, overflow_o drop pulse.
// Optional: TRDB_QUAL_STATS_EN adds qual_count_o and drop_count_o.
module trdb_qualify_tracker
  import trdb_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trace_enable_i,
  output logic            trace_activated_o,
  input  logic            trace_qualified_i,
  input  logic            trace_req_deactivate_i,
  input  logic            ivalid_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_iaddr_o,
  output logic            out_first_o,
  output logic            out_last_o,
  output logic            overflow_o
`ifdef TRDB_QUAL_STATS_EN
  ,
  output logic [31:0]     qual_count_o,
  output logic [15:0]     drop_count_o
`endif
);

  localparam bit TMO_EN = FLUSH_TIMEOUT > 0;
  localparam int CW =
    TMO_EN ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(FLUSH_TIMEOUT);

  qual_state_e r_state;
  logic        r_act;
  logic        r_hold_v;
  qual_entry_t r_hold;
  logic        r_prev_q;
  logic        r_pend;
  logic [CW-1:0] r_cnt;

  logic        w_proc;
  logic        w_idle_hold;
  logic [CW-1:0] w_cnt_inc;
  logic        w_tmo;
  logic        w_force;
  logic        w_emit;
  qual_entry_t w_emit_e;
  qual_entry_t w_out;
  logic        w_ovf;

  assign w_proc      = (r_state == ACTIVE) && ivalid_i;
  assign w_idle_hold = r_hold_v && !w_proc;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_tmo       = TMO_EN && (r_state == ACTIVE) &&
                       w_idle_hold && (w_cnt_inc == TMO);
  // Forced close of the run; never coincides with processing.
  assign w_force     = w_idle_hold &&
                       ((r_state == DRAIN) || flush_i ||
                        r_pend || w_tmo);
  assign w_emit      = w_force || (w_proc && r_hold_v);

  always_comb begin
    w_emit_e      = r_hold;
    w_emit_e.last = w_force || !trace_qualified_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_act   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (trace_enable_i) begin
          r_state <= ACTIVE;
          r_act   <= 1'b1;
        end
        ACTIVE: if (!trace_enable_i ||
                    (ivalid_i && trace_req_deactivate_i)) begin
          r_state <= DRAIN;
          r_act   <= 1'b0;
        end
        DRAIN: begin
          r_state <= trace_enable_i ? STOPPED : IDLE;
          r_act   <= 1'b0;
        end
        STOPPED: if (!trace_enable_i) begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_act   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_v <= 1'b0;
      r_hold   <= '0;
      r_prev_q <= 1'b0;
      r_pend   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // A flush seen alongside an instruction waits for a quiet cycle.
      r_pend <= w_proc ? (r_pend || flush_i) : 1'b0;

      if (w_force) begin
        r_hold_v <= 1'b0;
        r_prev_q <= 1'b0;
      end else if (w_proc) begin
        r_prev_q <= trace_qualified_i;
        r_hold_v <= trace_qualified_i;
        if (trace_qualified_i) begin
          r_hold.iaddr <= iaddr_i;
          r_hold.first <= !r_hold_v && !r_prev_q;
          r_hold.last  <= 1'b0;
        end
      end else if (r_state == DRAIN) begin
        r_prev_q <= 1'b0;
      end

      if (!TMO_EN || w_proc || w_force || !r_hold_v)
        r_cnt <= '0;
      else if (r_state == ACTIVE)
        r_cnt <= w_cnt_inc;
    end
  end

  trdb_qual_outreg u_outreg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_i       (w_emit),
    .wr_entry_i (w_emit_e),
    .ready_i    (out_ready_i),
    .valid_o    (out_valid_o),
    .entry_o    (w_out),
    .overflow_o (w_ovf)
  );

  assign trace_activated_o = r_act;
  assign out_iaddr_o       = w_out.iaddr;
  assign out_first_o       = w_out.first;
  assign out_last_o        = w_out.last;
  assign overflow_o        = w_ovf;

`ifdef TRDB_QUAL_STATS_EN
  logic [31:0] r_qual_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_qual_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (r_state == IDLE && trace_enable_i) begin
      r_qual_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_proc && trace_qualified_i && r_qual_cnt != '1)
        r_qual_cnt <= r_qual_cnt + 32'd1;
      if (w_ovf && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign qual_count_o = r_qual_cnt;
  assign drop_count_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_trdb_qualify_tracker.sv
// tb_trdb_qualify_tracker: directed scenarios plus random traffic
// compared every cycle against a run-level reference model.
module tb_trdb_qualify_tracker;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, tq, deact, iv, fl, rdy;
  logic [31:0] ia;
  logic        act, ov, of_, ol, ovf;
  logic [31:0] oa;
`ifdef TRDB_QUAL_STATS_EN
  logic [31:0] qc;
  logic [15:0] dc;
`endif

  int total = 0;
  int bad   = 0;
  int ovf_seen;

  // Reference model: trace on/draining/stopped flags, a 0/1 entry
  // hold, and the visible output slot.
  bit        m_on, m_drain, m_stop;
  bit        m_hv, m_hf;
  bit [31:0] m_ha;
  bit        m_prevq, m_pend;
  int        m_idle;
  bit        m_ov, m_of, m_ol, m_ovf;
  bit [31:0] m_oa;

  always #5 clk = ~clk;

  trdb_qualify_tracker #(.FLUSH_TIMEOUT(T)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .trace_enable_i         (en),
    .trace_activated_o      (act),
    .trace_qualified_i      (tq),
    .trace_req_deactivate_i (deact),
    .ivalid_i               (iv),
    .iaddr_i                (ia),
    .flush_i                (fl),
    .out_valid_o            (ov),
    .out_ready_i            (rdy),
    .out_iaddr_o            (oa),
    .out_first_o            (of_),
    .out_last_o             (ol),
    .overflow_o             (ovf)
`ifdef TRDB_QUAL_STATS_EN
    ,
    .qual_count_o           (qc),
    .drop_count_o           (dc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_stop = 0;
    m_hv = 0; m_hf = 0; m_ha = 0;
    m_prevq = 0; m_pend = 0; m_idle = 0;
    m_ov = 0; m_of = 0; m_ol = 0; m_ovf = 0; m_oa = 0;
  endtask

  task automatic model_step();
    bit emit, ef, el;
    bit [31:0] ea;
    emit = 0; ef = 0; el = 0; ea = 0;
    if (m_on && iv) begin
      m_idle = 0;
      if (m_hv) begin
        emit = 1; ea = m_ha; ef = m_hf; el = !tq;
      end
      if (tq) begin
        m_hf = !m_hv && !m_prevq;
        m_ha = ia;
      end
      m_hv = tq;
      m_prevq = tq;
      if (fl) m_pend = 1;
    end else begin
      if (m_hv && m_on) m_idle++;
      if (m_hv && (m_drain || fl || m_pend ||
                   (T > 0 && m_idle == T))) begin
        emit = 1; ea = m_ha; ef = m_hf; el = 1;
        m_hv = 0; m_prevq = 0; m_idle = 0;
      end
      if (m_drain) m_prevq = 0;
      m_pend = 0;
    end
    m_ovf = 0;
    if (emit) begin
      if (!m_ov || rdy) begin
        m_ov = 1; m_oa = ea; m_of = ef; m_ol = el;
      end else begin
        m_ovf = 1;
      end
    end else if (rdy) begin
      m_ov = 0;
    end
    if (m_on) begin
      if (!en || (iv && deact)) begin
        m_on = 0; m_drain = 1;
      end
    end else if (m_drain) begin
      m_drain = 0; m_stop = en;
    end else if (m_stop) begin
      if (!en) m_stop = 0;
    end else if (en) begin
      m_on = 1;
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (ovf) ovf_seen++;
    chk({tag, ".flags"}, 64'({act, ov, of_, ol, ovf}),
        64'({m_on, m_ov, m_of, m_ol, m_ovf}));
    chk({tag, ".addr"}, 64'(oa), 64'(m_oa));
  endtask

  task automatic ins(input bit v, input bit q,
                     input logic [31:0] a, input bit d,
                     input string tag);
    iv = v; tq = q; ia = a; deact = d;
    cyc(tag);
    iv = 0; tq = 0; deact = 0;
  endtask

  initial begin
    rst = 1; en = 0; tq = 0; deact = 0; iv = 0;
    fl = 0; rdy = 1; ia = 0; ovf_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", 64'({act, ov, oa, of_, ol, ovf}), 64'(0));
    rst = 0;

    // Qualified run of three closed by an unqualified instruction.
    en = 1;
    cyc("t1.en");
    chk("t1.act", 64'(act), 64'(1));
    ins(1, 1, 32'h100, 0, "t1.a");
    ins(1, 1, 32'h104, 0, "t1.b");
    chk("t1.e0", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h100, 1'b1, 1'b0}));
    ins(1, 1, 32'h108, 0, "t1.c");
    chk("t1.e1", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h104, 1'b0, 1'b0}));
    ins(1, 0, 32'h10C, 0, "t1.d");
    chk("t1.e2", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h108, 1'b0, 1'b1}));

    // Isolated qualified instruction is both first and last.
    ins(1, 0, 32'h110, 0, "t2.a");
    ins(1, 1, 32'h200, 0, "t2.b");
    ins(1, 0, 32'h204, 0, "t2.c");
    chk("t2.e", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h200, 1'b1, 1'b1}));

    // Deactivate request drains the held entry, then stop.
    ins(1, 1, 32'h300, 1, "t3.a");
    chk("t3.act0", 64'(act), 64'(0));
    cyc("t3.drain");
    chk("t3.e", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h300, 1'b1, 1'b1}));
    repeat (3) cyc("t3.stop");
    chk("t3.stopped", 64'(act), 64'(0));
    en = 0;
    cyc("t3.lo");
    en = 1;
    cyc("t3.hi");
    chk("t3.rearm", 64'(act), 64'(1));

    // Idle timeout closes the run; next instruction starts a new one.
    ins(1, 1, 32'h400, 0, "t4.a");
    repeat (3) cyc("t4.idle");
    chk("t4.notyet", 64'(ov), 64'(0));
    cyc("t4.tmo");
    chk("t4.e", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h400, 1'b1, 1'b1}));
    ins(1, 1, 32'h404, 0, "t4.b");
    ins(1, 0, 32'h408, 0, "t4.c");
    chk("t4.first", 64'({oa, of_, ol}),
        64'({32'h404, 1'b1, 1'b1}));

    // Flush coincident with an instruction acts a cycle later.
    ins(1, 1, 32'h700, 0, "tf.a");
    fl = 1;
    ins(1, 1, 32'h704, 0, "tf.b");
    fl = 0;
    cyc("tf.pend");
    chk("tf.e", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h704, 1'b0, 1'b1}));
    ins(1, 1, 32'h708, 0, "tf.c");
    ins(1, 0, 32'h70C, 0, "tf.d");
    chk("tf.first", 64'({oa, of_, ol}),
        64'({32'h708, 1'b1, 1'b1}));
    cyc("tf.drain");

    // Stalled consumer: first emission kept, two dropped.
    rdy = 0;
    ovf_seen = 0;
    ins(1, 1, 32'h500, 0, "t5.a");
    ins(1, 1, 32'h504, 0, "t5.b");
    ins(1, 1, 32'h508, 0, "t5.c");
    ins(1, 0, 32'h50C, 0, "t5.d");
    cyc("t5.q");
    chk("t5.ovf", 64'(ovf_seen), 64'(2));
    chk("t5.kept", 64'({ov, oa, of_, ol}),
        64'({1'b1, 32'h500, 1'b1, 1'b0}));
    rdy = 1;
    cyc("t5.acc");

    // Reset with both hold and output occupied.
    rdy = 0;
    ins(1, 1, 32'h600, 0, "t6.a");
    ins(1, 1, 32'h604, 0, "t6.b");
    rst = 1;
    #1;
    chk("t6.rst", 64'({act, ov}), 64'(0));
    model_reset();
    en = 0; rdy = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (6) cyc("t6.post");
    chk("t6.none", 64'(ov), 64'(0));

    // Random traffic.
    en = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) en = !en;
      iv    = $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3);
      tq    = $urandom_range(0, 9) < 6;
      ia    = $urandom & 32'hFFFF_FFFC;
      deact = $urandom_range(0, 39) == 0;
      fl    = $urandom_range(0, 24) == 0;
      rdy   = $urandom_range(0, 9) < 7;
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trdb_qualify_tracker.md
Name: trdb_qualify_tracker

Overview:
Downstream neighbour of the trace filter. Owns the trace activation state fed back to the filter (trace_activated) and consumes the filter's qualified and deactivate-request outputs per retired instruction. Buffers one qualified instruction so it can tag it first/last of a qualified run before handing it to packet generation. A first-tagged instruction forces a full-address packet; a last-tagged one closes the run.

Parameters:
FLUSH_TIMEOUT, 16, idle cycles after which a held instruction is emitted as last; 0 disables the timeout.
XLEN comes from trdb_pkg and is not a parameter.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
trace_enable_i  in  1  user tracing enable (level)
trace_activated_o  out  1  activation state, drives the filter's trace_activated_i
trace_qualified_i  in  1  from filter: current instruction qualified
trace_req_deactivate_i  in  1  from filter: stop-range hit
ivalid_i  in  1  instruction retired this cycle
iaddr_i  in  XLEN  retired instruction address
flush_i  in  1  force emission of the held instruction
out_valid_o  out  1  emitted instruction valid
out_ready_i  in  1  consumer accepts the emitted instruction
out_iaddr_o  out  XLEN  emitted address
out_first_o  out  1  first instruction of a qualified run
out_last_o  out  1  last instruction of a qualified run
overflow_o  out  1  one-cycle pulse: emission dropped

Behaviour:
- Reset: state IDLE; all outputs 0; holding register, prev_qualified, pending flush and timeout counter all cleared. Reset mid-run discards the held instruction with no emission.
- FSM:
  - IDLE (activated=0): goes to ACTIVE the cycle after trace_enable_i=1.
  - ACTIVE (activated=1): on trace_enable_i=0 goes to DRAIN. On ivalid_i and trace_req_deactivate_i, the instruction is processed normally, then state goes to DRAIN.
  - DRAIN (activated=0): emits the held entry as last if present (one cycle); goes to STOPPED if enable is still 1, else IDLE.
  - STOPPED (activated=0): stays until trace_enable_i=0, then IDLE. Re-arming requires an enable low->high.
- trace_activated_o is registered: =1 exactly while the state is ACTIVE.
- Instruction processing applies only in ACTIVE with ivalid_i. qualified = trace_qualified_i.
  - Qualified, hold empty: load hold with first = !prev_qualified.
  - Qualified, hold full: emit the held entry with last=0, then load the new entry with first=0.
  - Not qualified, hold full: emit the held entry with last=1 and clear hold.
  - Not qualified, hold empty: no emission.
  - prev_qualified is updated on every processed instruction.
- Forced last: flush_i, timeout, or DRAIN with the hold full emits the held entry with last=1, clears hold and clears prev_qualified, so the next qualified instruction is first=1.
  - flush_i coincident with ivalid_i sets a pending flag; the flush acts the next cycle without ivalid_i.
- Timeout: counter resets on load or ivalid_i and increments while the hold is full and idle. Reaching FLUSH_TIMEOUT triggers a forced last. Counter width is $clog2(FLUSH_TIMEOUT+1).
- Output register:
  - An emission writes out_* the cycle after the triggering event; latency 1.
  - out_valid_o stays high until out_valid_o && out_ready_i.
  - Acceptance and a new write in the same cycle are allowed.
  - If the register is occupied and not accepted when an emission is due: the register keeps its contents, the new emission is discarded, and overflow_o pulses for one cycle. Hold/prev_qualified update as if the emission succeeded.
- A single instruction can be first=1 and last=1 simultaneously.

Optional Feature:
- Macro TRDB_QUAL_STATS_EN. When defined, adds output qual_count_o [31:0] counting qualified processed instructions, plus drop_count_o [15:0] counting overflows.
  - Both counters saturate and clear on reset or on the IDLE->ACTIVE transition.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- trdb_pkg: XLEN; typedef qual_state_e {IDLE, ACTIVE, DRAIN, STOPPED}; struct qual_entry_t {iaddr, first, last}.
- One sub-module, trdb_qual_outreg: the single-entry valid/ready output register with overflow detection.

Test Plan:
- Enable=1, addresses 0x100,0x104,0x108, all qualified, then 0x10C unqualified -> emits 0x100(first=1,last=0), 0x104(0,0), 0x108(0,1); activated=1 one cycle after enable.
- Single qualified 0x200 between unqualified instructions -> one emission, first=1 and last=1.
- Qualified 0x300 with trace_req_deactivate_i=1 -> DRAIN emits 0x300 last=1; activated=0; STOPPED until enable toggles 0->1.
- FLUSH_TIMEOUT=4: hold 0x400, no ivalid_i for 4 cycles -> emitted last=1; next qualified 0x404 gets first=1.
- out_ready_i=0 with three qualified plus one unqualified instruction -> first emission retained, later emissions dropped, overflow_o pulses twice.
- Assert rst_i while hold and output are full -> out_valid_o=0 and activated=0 immediately; no emission after release.
